// File: rtl/byte_serial_tx.sv
// Byte serialiser: takes a byte on a store/ready handshake and shifts out a
// start bit, the data bits LSB first, an optional parity bit and a stop bit.
module byte_serial_tx #(
  parameter int unsigned DATA_WIDTH   = 8,
  parameter int unsigned CLKS_PER_BIT = 4,
  parameter int unsigned PARITY_EN    = 1,
  parameter int unsigned PARITY_ODD   = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [DATA_WIDTH-1:0] data,
  input  logic                  store,
  output logic                  ready,
  output logic                  busy,
  output logic                  tx,
  output logic                  done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT) + 1;
  localparam int unsigned BW = $clog2(DATA_WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_e;

  state_e                state_q, state_d;
  logic [CW-1:0]         clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]         bit_cnt_q, bit_cnt_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic                  parity_q, parity_d;
  logic                  tx_q, tx_d;
  logic                  ready_q, ready_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic slot_end;
  logic last_bit;
  logic accept;

  assign slot_end = (clk_cnt_q == '0);
  assign last_bit = (bit_cnt_q == '0);
  assign accept   = store && ready_q;

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= S_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic: each non-idle state ends when its slot's clock count runs out
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      S_IDLE:   if (accept)   state_d = S_START;
      S_START:  if (slot_end) state_d = S_DATA;
      S_DATA:   if (slot_end && last_bit) state_d = (PARITY_EN != 0) ? S_PARITY : S_STOP;
      S_PARITY: if (slot_end) state_d = S_STOP;
      S_STOP:   if (slot_end) state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  // Datapath and output next values; tx only moves at slot boundaries
  always_comb begin
    clk_cnt_d = clk_cnt_q;
    bit_cnt_d = bit_cnt_q;
    shift_d   = shift_q;
    parity_d  = parity_q;
    tx_d      = tx_q;
    ready_d   = ready_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
    if (state_q == S_IDLE) begin
      if (accept) begin
        shift_d   = data;
        parity_d  = (PARITY_ODD != 0) ? ~^data : ^data;
        tx_d      = 1'b0;
        clk_cnt_d = CW'(CLKS_PER_BIT - 1);
        ready_d   = 1'b0;
        busy_d    = 1'b1;
      end
    end else if (!slot_end) begin
      clk_cnt_d = clk_cnt_q - CW'(1);
    end else begin
      clk_cnt_d = CW'(CLKS_PER_BIT - 1);
      unique case (state_q)
        S_START: begin
          tx_d      = shift_q[0];
          shift_d   = shift_q >> 1;
          bit_cnt_d = BW'(DATA_WIDTH - 1);
        end
        S_DATA: begin
          if (last_bit) begin
            tx_d = (PARITY_EN != 0) ? parity_q : 1'b1;
          end else begin
            tx_d      = shift_q[0];
            shift_d   = shift_q >> 1;
            bit_cnt_d = bit_cnt_q - BW'(1);
          end
        end
        S_PARITY: tx_d = 1'b1;
        S_STOP: begin
          tx_d      = 1'b1;
          done_d    = 1'b1;
          ready_d   = 1'b1;
          busy_d    = 1'b0;
          clk_cnt_d = '0;
        end
        default: tx_d = 1'b1;
      endcase
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      ready_q   <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      clk_cnt_q <= clk_cnt_d;
      bit_cnt_q <= bit_cnt_d;
      shift_q   <= shift_d;
      parity_q  <= parity_d;
      tx_q      <= tx_d;
      ready_q   <= ready_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign tx    = tx_q;
  assign ready = ready_q;
  assign busy  = busy_q;
  assign done  = done_q;

endmodule

// File: tb/tb_byte_serial_tx.sv
// Scoreboard bench for byte_serial_tx: four parameterisations, directed frames
// followed by random traffic, every line cycle compared against a frame model.
module tb_byte_serial_tx;

  logic       clk;
  logic [3:0] rst_a;
  logic [3:0] store_a;
  logic [7:0] data_a [4];
  logic [3:0] tx_w, ready_w, busy_w, done_w;

  int tests;
  int fails;

  typedef struct {
    int          inst;
    logic [15:0] bits;
    int          nb;
    bit          b2b;
  } exp_t;
  exp_t sb[$];

  // Instance 0: defaults; 1: one clock per bit; 2: odd parity; 3: no parity
  byte_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(1), .PARITY_ODD(0)) u_dut0 (
    .clk(clk), .rst_n(rst_a[0]), .data(data_a[0]), .store(store_a[0]),
    .ready(ready_w[0]), .busy(busy_w[0]), .tx(tx_w[0]), .done(done_w[0]));
  byte_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(1), .PARITY_EN(1), .PARITY_ODD(0)) u_dut1 (
    .clk(clk), .rst_n(rst_a[1]), .data(data_a[1]), .store(store_a[1]),
    .ready(ready_w[1]), .busy(busy_w[1]), .tx(tx_w[1]), .done(done_w[1]));
  byte_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(2), .PARITY_EN(1), .PARITY_ODD(1)) u_dut2 (
    .clk(clk), .rst_n(rst_a[2]), .data(data_a[2]), .store(store_a[2]),
    .ready(ready_w[2]), .busy(busy_w[2]), .tx(tx_w[2]), .done(done_w[2]));
  byte_serial_tx #(.DATA_WIDTH(8), .CLKS_PER_BIT(4), .PARITY_EN(0), .PARITY_ODD(0)) u_dut3 (
    .clk(clk), .rst_n(rst_a[3]), .data(data_a[3]), .store(store_a[3]),
    .ready(ready_w[3]), .busy(busy_w[3]), .tx(tx_w[3]), .done(done_w[3]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic int cpb_of(int i);
    case (i)
      1:       return 1;
      2:       return 2;
      default: return 4;
    endcase
  endfunction

  function automatic int pen_of(int i);
    return (i == 3) ? 0 : 1;
  endfunction

  function automatic int podd_of(int i);
    return (i == 2) ? 1 : 0;
  endfunction

  // Expected line value per slot: start, data LSB first, optional parity, stop
  function automatic logic [15:0] frame_bits(logic [7:0] d, int pen, int podd, output int nb);
    logic [15:0] b;
    int ones;
    b = '1;
    b[0] = 1'b0;
    ones = 0;
    for (int j = 0; j < 8; j++) begin
      b[1+j] = d[j];
      ones += int'(d[j]);
    end
    if (pen != 0) begin
      b[9] = ((ones % 2) != podd) ? 1'b1 : 1'b0;
      nb = 11;
    end else begin
      nb = 10;
    end
    return b;
  endfunction

  task automatic chk(string name, int act, int exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, act, exp);
    end
  endtask

  // Monitor: per-instance frame tracking against popped expectations
  int          cyc      [4];
  bit          active   [4];
  bit          done_nx  [4];
  int          idle_cnt [4];
  logic [15:0] cur_bits [4];
  int          cur_n    [4];

  initial begin
    for (int i = 0; i < 4; i++) begin
      cyc[i] = 0; active[i] = 1'b0; done_nx[i] = 1'b0; idle_cnt[i] = 1;
      cur_bits[i] = '1; cur_n[i] = 0;
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 4; i++) begin
      int obs;
      obs = int'({tx_w[i], ready_w[i], busy_w[i], done_w[i]});
      if (!rst_a[i]) begin
        chk($sformatf("reset_outputs[%0d]", i), obs, 4'b1100);
        active[i] = 1'b0; done_nx[i] = 1'b0; idle_cnt[i] = 1;
      end else begin
        if (!active[i] && !done_nx[i] && busy_w[i]) begin
          if (sb.size() == 0) begin
            chk($sformatf("unexpected_frame[%0d]", i), 1, 0);
            cur_bits[i] = '1; cur_n[i] = 11;
          end else begin
            exp_t e;
            e = sb.pop_front();
            chk("frame_instance", i, e.inst);
            if (e.b2b) chk($sformatf("b2b_idle_gap[%0d]", i), idle_cnt[i], 0);
            cur_bits[i] = e.bits; cur_n[i] = e.nb;
          end
          active[i] = 1'b1; cyc[i] = 0;
        end
        if (active[i]) begin
          int slot;
          slot = cyc[i] / cpb_of(i);
          chk($sformatf("frame[%0d] slot %0d cyc %0d {tx,rdy,busy,done}", i, slot, cyc[i]),
              obs, int'({cur_bits[i][slot], 3'b010}));
          cyc[i]++;
          if (cyc[i] == cur_n[i] * cpb_of(i)) begin
            active[i] = 1'b0; done_nx[i] = 1'b1;
          end
        end else if (done_nx[i]) begin
          chk($sformatf("done_cycle[%0d]", i), obs, 4'b1101);
          done_nx[i] = 1'b0; idle_cnt[i] = 0;
        end else begin
          chk($sformatf("idle[%0d]", i), obs, 4'b1100);
          idle_cnt[i]++;
        end
      end
    end
  end

  task automatic push_frame(int i, logic [7:0] d, bit b2b);
    exp_t e;
    e.inst = i;
    e.bits = frame_bits(d, pen_of(i), podd_of(i), e.nb);
    e.b2b  = b2b;
    sb.push_back(e);
  endtask

  // Called at a falling edge; returns at the falling edge of the done cycle.
  // hold=1 keeps store high with hold_d on data through the frame.
  task automatic send(int i, logic [7:0] d, bit b2b, bit hold, logic [7:0] hold_d);
    int n;
    int nb;
    logic [15:0] unused_bits;
    unused_bits = frame_bits(d, pen_of(i), podd_of(i), nb);
    n = nb * cpb_of(i);
    store_a[i] = 1'b1;
    data_a[i]  = d;
    push_frame(i, d, b2b);
    @(negedge clk);
    store_a[i] = hold;
    data_a[i]  = hold ? hold_d : 8'($urandom);
    for (int j = 1; j <= n; j++) begin
      @(negedge clk);
      if (hold) begin
        store_a[i] = 1'b1; data_a[i] = hold_d;
      end else if (j < n) begin
        store_a[i] = 1'($urandom); data_a[i] = 8'($urandom);
      end else begin
        store_a[i] = 1'b0;
      end
    end
  endtask

  task automatic reset_mid_frame(int i, logic [7:0] d);
    store_a[i] = 1'b1;
    data_a[i]  = d;
    push_frame(i, d, 1'b0);
    @(negedge clk);
    store_a[i] = 1'b0;
    repeat (4 * cpb_of(i)) @(negedge clk);
    #2 rst_a[i] = 1'b0;
    #1 chk($sformatf("async_reset[%0d]", i),
           int'({tx_w[i], ready_w[i], busy_w[i], done_w[i]}), 4'b1100);
    @(negedge clk);
    @(negedge clk);
    #2 rst_a[i] = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    int prev;
    tests = 0;
    fails = 0;
    rst_a   = 4'b0000;
    store_a = 4'b0000;
    for (int i = 0; i < 4; i++) data_a[i] = 8'h00;
    repeat (3) @(negedge clk);
    #2 rst_a = 4'b1111;
    repeat (20) @(negedge clk);

    send(0, 8'hA5, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    send(0, 8'h3C, 1'b0, 1'b1, 8'hC3);
    send(0, 8'hC3, 1'b1, 1'b0, 8'h00);
    repeat (2) @(negedge clk);
    reset_mid_frame(0, 8'h77);
    repeat (2) @(negedge clk);
    send(0, 8'h5A, 1'b0, 1'b0, 8'h00);
    send(1, 8'h80, 1'b0, 1'b0, 8'h00);
    send(1, 8'h01, 1'b1, 1'b0, 8'h00);
    send(2, 8'h01, 1'b0, 1'b0, 8'h00);
    send(2, 8'h00, 1'b1, 1'b0, 8'h00);
    send(3, 8'hFF, 1'b0, 1'b0, 8'h00);
    reset_mid_frame(1, 8'h5A);
    send(1, 8'h5A, 1'b0, 1'b0, 8'h00);

    prev = 1;
    for (int t = 0; t < 60; t++) begin
      int i;
      int gap;
      i   = int'($urandom_range(0, 3));
      gap = int'($urandom_range(0, 2));
      repeat (gap) @(negedge clk);
      send(i, 8'($urandom), (gap == 0) && (i == prev), 1'b0, 8'h00);
      prev = i;
    end

    repeat (20) @(negedge clk);
    chk("scoreboard_drained", sb.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
